// File: rtl/combat_engine.sv
// Two-fighter combat resolver: decodes both action codes per step strobe, applies
// saturating damage with block halving and heavy-attack cooldown, and runs the round FSM.
//
// state   | meaning
// S_IDLE  | waiting for first start; healths held at MAX_HEALTH
// S_FIGHT | round in progress; each step resolves one exchange
// S_OVER  | a fighter reached 0; results frozen until start
module combat_engine #(
  parameter int HEALTH_W    = 7,
  parameter int MAX_HEALTH  = 100,
  parameter int ATTACK_DMG  = 10,
  parameter int HEAVY_DMG   = 25,
  parameter int BLOCK_SHIFT = 1,
  parameter int COOLDOWN    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                step,
  input  logic [3:0]          keyboard_input,
  input  logic [3:0]          cpu_input,
  output logic [HEALTH_W-1:0] p1_health_out,
  output logic [HEALTH_W-1:0] cpu_health_out,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic                p1_heavy_ready,
  output logic                cpu_heavy_ready
);

  localparam int AW   = HEALTH_W + 1;
  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [HEALTH_W-1:0] MAX_HP = HEALTH_W'(MAX_HEALTH);
  localparam logic [AW-1:0]       ATK_D  = AW'(ATTACK_DMG);
  localparam logic [AW-1:0]       HVY_D  = AW'(HEAVY_DMG);
  localparam logic [CD_W-1:0]     CD_LD  = CD_W'(COOLDOWN);

  typedef enum logic [1:0] {S_IDLE, S_FIGHT, S_OVER} state_t;
  typedef enum logic [1:0] {A_IDLE, A_ATK, A_BLK, A_HVY} act_t;

  state_t              state, state_nxt;
  logic [HEALTH_W-1:0] p1_hp, cpu_hp, p1_hp_nxt, cpu_hp_nxt;
  logic [HEALTH_W-1:0] p1_after, cpu_after;
  logic [CD_W-1:0]     p1_cd, cpu_cd, p1_cd_nxt, cpu_cd_nxt;
  logic [CD_W-1:0]     p1_cd_step, cpu_cd_step;
  logic [1:0]          winner_r, winner_nxt;
  logic [AW-1:0]       dmg_to_p1, dmg_to_cpu;
  act_t                p1_act, cpu_act;

  // A heavy attack still on cooldown degrades to idle rather than a normal attack.
  function automatic act_t decode(input logic [3:0] code, input logic cd_busy);
    case (code)
      4'd1:    return A_ATK;
      4'd2:    return A_BLK;
      4'd3:    return cd_busy ? A_IDLE : A_HVY;
      default: return A_IDLE;
    endcase
  endfunction

  function automatic logic [AW-1:0] dmg_of(input act_t a);
    case (a)
      A_ATK:   return ATK_D;
      A_HVY:   return HVY_D;
      default: return '0;
    endcase
  endfunction

  function automatic logic [HEALTH_W-1:0] apply_dmg(input logic [HEALTH_W-1:0] hp,
                                                    input logic [AW-1:0] dmg);
    logic [AW-1:0] hp_x;
    hp_x = {1'b0, hp};
    return (hp_x <= dmg) ? '0 : HEALTH_W'(hp_x - dmg);
  endfunction

  function automatic logic [CD_W-1:0] cd_update(input logic [CD_W-1:0] cd, input act_t a);
    if (a == A_HVY)  return CD_LD;
    else if (cd != '0) return cd - CD_W'(1);
    else             return cd;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      p1_hp    <= MAX_HP;
      cpu_hp   <= MAX_HP;
      p1_cd    <= '0;
      cpu_cd   <= '0;
      winner_r <= 2'b00;
    end else begin
      state    <= state_nxt;
      p1_hp    <= p1_hp_nxt;
      cpu_hp   <= cpu_hp_nxt;
      p1_cd    <= p1_cd_nxt;
      cpu_cd   <= cpu_cd_nxt;
      winner_r <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    p1_hp_nxt  = p1_hp;
    cpu_hp_nxt = cpu_hp;
    p1_cd_nxt  = p1_cd;
    cpu_cd_nxt = cpu_cd;
    winner_nxt = winner_r;

    p1_act     = decode(keyboard_input, p1_cd != '0);
    cpu_act    = decode(cpu_input, cpu_cd != '0);
    dmg_to_cpu = dmg_of(p1_act);
    dmg_to_p1  = dmg_of(cpu_act);
    if (cpu_act == A_BLK) dmg_to_cpu = dmg_to_cpu >> BLOCK_SHIFT;
    if (p1_act == A_BLK)  dmg_to_p1  = dmg_to_p1 >> BLOCK_SHIFT;
    p1_after    = apply_dmg(p1_hp, dmg_to_p1);
    cpu_after   = apply_dmg(cpu_hp, dmg_to_cpu);
    p1_cd_step  = cd_update(p1_cd, p1_act);
    cpu_cd_step = cd_update(cpu_cd, cpu_act);

    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nxt  = S_FIGHT;
          p1_hp_nxt  = MAX_HP;
          cpu_hp_nxt = MAX_HP;
          p1_cd_nxt  = '0;
          cpu_cd_nxt = '0;
          winner_nxt = 2'b00;
        end
      end
      S_FIGHT: begin
        if (step) begin
          p1_hp_nxt  = p1_after;
          cpu_hp_nxt = cpu_after;
          p1_cd_nxt  = p1_cd_step;
          cpu_cd_nxt = cpu_cd_step;
          if (p1_after == '0 || cpu_after == '0) begin
            state_nxt  = S_OVER;
            winner_nxt = {p1_after == '0, cpu_after == '0};
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign p1_health_out   = p1_hp;
  assign cpu_health_out  = cpu_hp;
  assign game_over       = (state == S_OVER);
  assign winner          = winner_r;
  assign p1_heavy_ready  = (p1_cd == '0);
  assign cpu_heavy_ready = (cpu_cd == '0);

endmodule

// File: tb/tb_combat_engine.sv
// Directed self-checking bench for combat_engine; one task per scenario.
module tb_combat_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic [3:0] keyboard_input = 4'd0;
  logic [3:0] cpu_input = 4'd0;
  logic [6:0] p1_health_out, cpu_health_out;
  logic       game_over;
  logic [1:0] winner;
  logic       p1_heavy_ready, cpu_heavy_ready;

  int errors = 0;
  int checks = 0;

  combat_engine dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .keyboard_input(keyboard_input), .cpu_input(cpu_input),
    .p1_health_out(p1_health_out), .cpu_health_out(cpu_health_out),
    .game_over(game_over), .winner(winner),
    .p1_heavy_ready(p1_heavy_ready), .cpu_heavy_ready(cpu_heavy_ready)
  );

  always #5 clk = ~clk;

  // All drivers change inputs 1ns after a rising edge and return at the same phase.
  task automatic do_step(input logic [3:0] k, input logic [3:0] c);
    keyboard_input = k; cpu_input = c; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0; keyboard_input = 4'd0; cpu_input = 4'd0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1; #3; reset = 1'b0;
    @(posedge clk); #1;
    do_start();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (p1_health_out !== 7'd100) begin errors++; $display("FAIL rst_p1_hp got=%0d exp=100", p1_health_out); end
    checks++; if (cpu_health_out !== 7'd100) begin errors++; $display("FAIL rst_cpu_hp got=%0d exp=100", cpu_health_out); end
    checks++; if ({game_over, winner} !== 3'b000) begin errors++; $display("FAIL rst_over_win got=%b exp=000", {game_over, winner}); end
    checks++; if ({p1_heavy_ready, cpu_heavy_ready} !== 2'b11) begin errors++; $display("FAIL rst_ready got=%b exp=11", {p1_heavy_ready, cpu_heavy_ready}); end
    reset = 1'b0;
  endtask

  task automatic test_attack();
    restart();
    do_step(4'd1, 4'd0);
    checks++; if (cpu_health_out !== 7'd90) begin errors++; $display("FAIL atk_cpu_hp got=%0d exp=90", cpu_health_out); end
    checks++; if (p1_health_out !== 7'd100) begin errors++; $display("FAIL atk_p1_hp got=%0d exp=100", p1_health_out); end
    checks++; if ({game_over, winner} !== 3'b000) begin errors++; $display("FAIL atk_over_win got=%b exp=000", {game_over, winner}); end
  endtask

  task automatic test_heavy_cooldown();
    restart();
    do_step(4'd3, 4'd2);
    checks++; if (cpu_health_out !== 7'd88) begin errors++; $display("FAIL hvy_blocked_cpu_hp got=%0d exp=88", cpu_health_out); end
    checks++; if (p1_health_out !== 7'd100) begin errors++; $display("FAIL hvy_blocker_dmg got=%0d exp=100", p1_health_out); end
    checks++; if (p1_heavy_ready !== 1'b0) begin errors++; $display("FAIL hvy_ready_after_fire got=%b exp=0", p1_heavy_ready); end
    do_step(4'd3, 4'd0);
    checks++; if (cpu_health_out !== 7'd88) begin errors++; $display("FAIL hvy_locked_cpu_hp got=%0d exp=88", cpu_health_out); end
    do_step(4'd0, 4'd0);
    checks++; if (p1_heavy_ready !== 1'b0) begin errors++; $display("FAIL hvy_ready_2steps got=%b exp=0", p1_heavy_ready); end
    // step=0 cycles must not advance the cooldown
    repeat (3) @(posedge clk);
    #1;
    checks++; if (p1_heavy_ready !== 1'b0) begin errors++; $display("FAIL hvy_ready_nostep got=%b exp=0", p1_heavy_ready); end
    do_step(4'd0, 4'd0);
    checks++; if (p1_heavy_ready !== 1'b1) begin errors++; $display("FAIL hvy_ready_3steps got=%b exp=1", p1_heavy_ready); end
    do_step(4'd3, 4'd0);
    checks++; if (cpu_health_out !== 7'd63) begin errors++; $display("FAIL hvy_land_cpu_hp got=%0d exp=63", cpu_health_out); end
    do_step(4'd0, 4'd3);
    checks++; if (p1_health_out !== 7'd75) begin errors++; $display("FAIL hvy_cpu_land_p1_hp got=%0d exp=75", p1_health_out); end
    checks++; if ({p1_heavy_ready, cpu_heavy_ready} !== 2'b00) begin errors++; $display("FAIL hvy_both_ready got=%b exp=00", {p1_heavy_ready, cpu_heavy_ready}); end
  endtask

  task automatic test_simultaneous();
    restart();
    do_step(4'd1, 4'd1);
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd90, 7'd90}) begin errors++; $display("FAIL sim_both got=%0d/%0d exp=90/90", p1_health_out, cpu_health_out); end
    keyboard_input = 4'd1; cpu_input = 4'd1; step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd90, 7'd90}) begin errors++; $display("FAIL sim_nostep got=%0d/%0d exp=90/90", p1_health_out, cpu_health_out); end
    do_step(4'd2, 4'd0);
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd90, 7'd90}) begin errors++; $display("FAIL block_vs_idle got=%0d/%0d exp=90/90", p1_health_out, cpu_health_out); end
    do_step(4'd1, 4'd2);
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd90, 7'd85}) begin errors++; $display("FAIL atk_blocked got=%0d/%0d exp=90/85", p1_health_out, cpu_health_out); end
  endtask

  task automatic test_knockout();
    restart();
    repeat (9) do_step(4'd1, 4'd0);
    checks++; if ({cpu_health_out, game_over} !== {7'd10, 1'b0}) begin errors++; $display("FAIL ko_pre got=%0d/%b exp=10/0", cpu_health_out, game_over); end
    do_step(4'd1, 4'd0);
    checks++; if (cpu_health_out !== 7'd0) begin errors++; $display("FAIL ko_cpu_hp got=%0d exp=0", cpu_health_out); end
    checks++; if ({game_over, winner} !== 3'b101) begin errors++; $display("FAIL ko_over_win got=%b exp=101", {game_over, winner}); end
    do_step(4'd0, 4'd1);
    do_step(4'd1, 4'd3);
    checks++; if ({p1_health_out, cpu_health_out, game_over, winner, cpu_heavy_ready} !== {7'd100, 7'd0, 1'b1, 2'b01, 1'b1})
      begin errors++; $display("FAIL ko_frozen got=%0d/%0d/%b/%b exp=100/0/1/01", p1_health_out, cpu_health_out, game_over, winner); end
    do_start();
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd100, 7'd100}) begin errors++; $display("FAIL ko_restart_hp got=%0d/%0d exp=100/100", p1_health_out, cpu_health_out); end
    checks++; if ({game_over, winner} !== 3'b000) begin errors++; $display("FAIL ko_restart_flags got=%b exp=000", {game_over, winner}); end
    restart();
    repeat (10) do_step(4'd0, 4'd1);
    checks++; if ({p1_health_out, winner} !== {7'd0, 2'b10}) begin errors++; $display("FAIL ko_cpu_wins got=%0d/%b exp=0/10", p1_health_out, winner); end
  endtask

  task automatic test_draw_and_saturate();
    restart();
    repeat (9) do_step(4'd1, 4'd1);
    checks++; if ({p1_health_out, cpu_health_out, game_over} !== {7'd10, 7'd10, 1'b0}) begin errors++; $display("FAIL draw_pre got=%0d/%0d/%b exp=10/10/0", p1_health_out, cpu_health_out, game_over); end
    do_step(4'd1, 4'd1);
    checks++; if ({p1_health_out, cpu_health_out, game_over, winner} !== {7'd0, 7'd0, 1'b1, 2'b11})
      begin errors++; $display("FAIL draw got=%0d/%0d/%b/%b exp=0/0/1/11", p1_health_out, cpu_health_out, game_over, winner); end
    restart();
    repeat (9) do_step(4'd1, 4'd1);
    do_step(4'd3, 4'd0);
    checks++; if ({p1_health_out, cpu_health_out, winner} !== {7'd10, 7'd0, 2'b01})
      begin errors++; $display("FAIL heavy_saturate got=%0d/%0d/%b exp=10/0/01", p1_health_out, cpu_health_out, winner); end
  endtask

  task automatic test_reset_mid_and_idle();
    restart();
    do_step(4'd1, 4'd0);
    keyboard_input = 4'd1; step = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (cpu_health_out !== 7'd100) begin errors++; $display("FAIL midrst_cpu_hp got=%0d exp=100", cpu_health_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    do_step(4'd1, 4'd0);
    checks++; if (cpu_health_out !== 7'd100) begin errors++; $display("FAIL idle_step_ignored got=%0d exp=100", cpu_health_out); end
    start = 1'b1;
    do_step(4'd1, 4'd1);
    start = 1'b0;
    checks++; if ({p1_health_out, cpu_health_out, game_over} !== {7'd100, 7'd100, 1'b0}) begin errors++; $display("FAIL start_step_discard got=%0d/%0d/%b exp=100/100/0", p1_health_out, cpu_health_out, game_over); end
    do_step(4'd7, 4'd15);
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd100, 7'd100}) begin errors++; $display("FAIL codes_7_15 got=%0d/%0d exp=100/100", p1_health_out, cpu_health_out); end
    do_step(4'd7, 4'd1);
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd90, 7'd100}) begin errors++; $display("FAIL code7_idle got=%0d/%0d exp=90/100", p1_health_out, cpu_health_out); end
    do_step(4'd1, 4'd15);
    checks++; if ({p1_health_out, cpu_health_out} !== {7'd90, 7'd90}) begin errors++; $display("FAIL code15_idle got=%0d/%0d exp=90/90", p1_health_out, cpu_health_out); end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_heavy_cooldown();
    test_simultaneous();
    test_knockout();
    test_draw_and_saturate();
    test_reset_mid_and_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
